// File: rtl/alu_seq.sv
// Handshaked ALU (ADD/SUB/AND/OR) followed by an optional one-bit-per-cycle shift/rotate phase.
// Optional signed-overflow output vout is enabled by defining ALU_SEQ_OVF_EN.
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         ALU_sel,
    input  logic [1:0]         load_shift,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               cout,
`ifdef ALU_SEQ_OVF_EN
    output logic               vout,
`endif
    output logic               zout
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   acc;
    logic               carry;
    logic               zflag;
    logic [SHAMT_W-1:0] count;
    logic [1:0]         mode;
    logic               accept;
    logic               go_shift;
    logic [WIDTH:0]     op_res;
    logic [WIDTH:0]     step;

    // {carry, value}; SUB carry is the inverted borrow
    function automatic logic [WIDTH:0] alu_op(input logic [1:0] sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        case (sel)
            2'b00:   alu_op = {1'b0, x} + {1'b0, y};
            2'b01:   alu_op = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
            2'b10:   alu_op = {1'b0, x & y};
            default: alu_op = {1'b0, x | y};
        endcase
    endfunction

    // {bit shifted out, shifted value}
    function automatic logic [WIDTH:0] shift_step(input logic [1:0] md,
                                                  input logic [WIDTH-1:0] v);
        case (md)
            2'b01:   shift_step = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            2'b10:   shift_step = {v[0], 1'b0, v[WIDTH-1:1]};
            2'b11:   shift_step = {v[0], v[0], v[WIDTH-1:1]};
            default: shift_step = {1'b0, v};
        endcase
    endfunction

`ifdef ALU_SEQ_OVF_EN
    function automatic logic ovf_calc(input logic [1:0] sel,
                                      input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y,
                                      input logic [WIDTH-1:0] r);
        logic signed [WIDTH-1:0] sx, sy, sr;
        sx = x;
        sy = y;
        sr = r;
        case (sel)
            2'b00:   ovf_calc = ((sx < 0) == (sy < 0)) && ((sr < 0) != (sx < 0));
            2'b01:   ovf_calc = ((sx < 0) != (sy < 0)) && ((sr < 0) != (sx < 0));
            default: ovf_calc = 1'b0;
        endcase
    endfunction
`endif

    assign op_res   = alu_op(ALU_sel, a, b);
    assign step     = shift_step(mode, acc);
    assign go_shift = (load_shift != 2'b00) && (shamt != '0);
    assign accept   = in_valid && in_ready;

    assign result = acc;
    assign cout   = carry;
    assign zout   = zflag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = go_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (count == SHAMT_W'(1)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) state_next = go_shift ? SHIFT : DONE;
                    else          state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands sampled only on accept; the shift phase works on acc alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            carry <= 1'b0;
            zflag <= 1'b0;
            count <= '0;
            mode  <= 2'b00;
        end else if (accept) begin
            acc   <= op_res[WIDTH-1:0];
            carry <= op_res[WIDTH];
            zflag <= (op_res[WIDTH-1:0] == '0);
            count <= shamt;
            mode  <= load_shift;
        end else if (state == SHIFT) begin
            acc   <= step[WIDTH-1:0];
            carry <= step[WIDTH];
            zflag <= (step[WIDTH-1:0] == '0);
            count <= count - SHAMT_W'(1);
        end
    end

`ifdef ALU_SEQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      vout <= 1'b0;
        else if (accept) vout <= ovf_calc(ALU_sel, a, b, op_res[WIDTH-1:0]);
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vector table, handshake/reset sequences,
// and randomized operations against a closed-form reference model.
module tb_alu_seq;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic [1:0] ALU_sel, load_shift;
    logic [2:0] shamt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       cout, zout;
`ifdef ALU_SEQ_OVF_EN
    logic       vout;
`endif

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALU_sel(ALU_sel), .load_shift(load_shift), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout),
`ifdef ALU_SEQ_OVF_EN
        .vout(vout),
`endif
        .zout(zout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic [1:0] ls;
        logic [2:0] sh;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] er;
        logic       ec;
        logic       ez;
        logic       ev;
        int         el;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Closed-form reference: integer arithmetic plus a single n-bit shift/rotate
    task automatic model(input logic [1:0] sel, input logic [1:0] ls, input logic [2:0] sh,
                         input logic [7:0] x, input logic [7:0] y,
                         output logic [7:0] r, output logic c, output logic z,
                         output logic v, output int lat);
        int ux, uy, sx, sy, s, res, n;
        ux = x; uy = y;
        sx = (ux >= 128) ? ux - 256 : ux;
        sy = (uy >= 128) ? uy - 256 : uy;
        v = 1'b0;
        c = 1'b0;
        case (sel)
            2'd0: begin s = ux + uy; res = s & MASK; c = (s > MASK);
                        v = (sx + sy > 127) || (sx + sy < -128); end
            2'd1: begin s = ux - uy; res = s & MASK; c = (ux >= uy);
                        v = (sx - sy > 127) || (sx - sy < -128); end
            2'd2: res = ux & uy;
            default: res = ux | uy;
        endcase
        n = (ls != 2'd0) ? int'(sh) : 0;
        if (n > 0) begin
            case (ls)
                2'd1: begin c = ((res >> (W - n)) & 1) != 0; res = (res << n) & MASK; end
                2'd2: begin c = ((res >> (n - 1)) & 1) != 0; res = res >> n; end
                default: begin c = ((res >> (n - 1)) & 1) != 0;
                               res = ((res >> n) | (res << (W - n))) & MASK; end
            endcase
        end
        r   = res[7:0];
        z   = (res == 0);
        lat = (n > 0) ? n + 1 : 1;
    endtask

    task automatic do_op(input string name, input logic [1:0] s, input logic [1:0] l,
                         input logic [2:0] sh, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic ec, input logic ez,
                         input logic ev, input int el);
        int lat;
        bit got;
        @(negedge clk);
        ALU_sel = s; load_shift = l; shamt = sh; a = x; b = y; in_valid = 1'b1;
        chk({name, "/in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); ALU_sel = 2'($urandom);
        load_shift = 2'($urandom); shamt = 3'($urandom);
        lat = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1;
        end
        chk({name, "/latency"}, lat, el);
        chk({name, "/result"}, result, er);
        chk({name, "/cout"}, cout, ec);
        chk({name, "/zout"}, zout, ez);
`ifdef ALU_SEQ_OVF_EN
        chk({name, "/vout"}, vout, ev);
`endif
    endtask

    vec_t vecs[13];

    initial begin
        logic [7:0] mr;
        logic mc, mz, mv;
        int ml;
        logic [1:0] rs, rl;
        logic [2:0] rsh;
        logic [7:0] ra, rb;
        bit got;

        vecs[0]  = '{2'd0, 2'd0, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vecs[1]  = '{2'd1, 2'd0, 3'd0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1};
        vecs[2]  = '{2'd1, 2'd0, 3'd0, 8'h07, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vecs[3]  = '{2'd2, 2'd1, 3'd3, 8'hF0, 8'h3C, 8'h80, 1'b1, 1'b0, 1'b0, 4};
        vecs[4]  = '{2'd3, 2'd3, 3'd1, 8'h81, 8'h00, 8'hC0, 1'b1, 1'b0, 1'b0, 2};
        vecs[5]  = '{2'd3, 2'd2, 3'd7, 8'h80, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8};
        vecs[6]  = '{2'd0, 2'd0, 3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1};
        vecs[7]  = '{2'd2, 2'd0, 3'd0, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vecs[8]  = '{2'd0, 2'd1, 3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{2'd1, 2'd2, 3'd1, 8'h00, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 2};
        vecs[10] = '{2'd0, 2'd0, 3'd5, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1};
        vecs[11] = '{2'd3, 2'd1, 3'd7, 8'h03, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 8};
        vecs[12] = '{2'd3, 2'd2, 3'd1, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 2};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ALU_sel = '0; load_shift = '0; shamt = '0;
        repeat (2) @(negedge clk);
        chk("reset/out_valid", out_valid, 0);
        chk("reset/result", result, 0);
        chk("reset/cout", cout, 0);
        chk("reset/zout", zout, 0);
        chk("reset/in_ready", in_ready, 1);
        rst_n = 1'b1;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].ls, vecs[i].sh, vecs[i].x,
                  vecs[i].y, vecs[i].er, vecs[i].ec, vecs[i].ez, vecs[i].ev, vecs[i].el);

        // Back-pressure in DONE, then retire + accept on the same edge
        @(negedge clk);
        out_ready = 1'b0;
        ALU_sel = 2'd0; load_shift = 2'd0; shamt = 3'd0; a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(posedge clk);
        #1;
        ALU_sel = 2'd2; a = 8'h00; b = 8'h00;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        chk("hold/reached", got, 1);
        for (int k = 0; k < 5; k++) begin
            chk("hold/result", result, 8'h46);
            chk("hold/cout", cout, 0);
            chk("hold/zout", zout, 0);
            chk("hold/in_ready", in_ready, 0);
            chk("hold/out_valid", out_valid, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        ALU_sel = 2'd1; a = 8'h50; b = 8'h10;
        #1;
        chk("b2b/in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b/out_valid", out_valid, 1);
        chk("b2b/result", result, 8'h40);
        chk("b2b/cout", cout, 1);
        chk("b2b/zout", zout, 0);
        @(negedge clk);
        chk("idle/out_valid", out_valid, 0);
        chk("idle/result_kept", result, 8'h40);
        chk("idle/in_ready", in_ready, 1);

        // Asynchronous reset in the middle of a shift
        ALU_sel = 2'd3; load_shift = 2'd1; shamt = 3'd7; a = 8'h03; b = 8'h00; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midshift/out_valid", out_valid, 0);
        chk("midshift/in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("arst/out_valid", out_valid, 0);
        chk("arst/result", result, 0);
        chk("arst/cout", cout, 0);
        chk("arst/zout", zout, 0);
        chk("arst/in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_reset", 2'd0, 2'd0, 3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1);

        for (int i = 0; i < 150; i++) begin
            rs = 2'($urandom); rl = 2'($urandom); rsh = 3'($urandom);
            ra = 8'($urandom); rb = 8'($urandom);
            if ((i % 10) == 0) ra = rb;
            model(rs, rl, rsh, ra, rb, mr, mc, mz, mv, ml);
            do_op($sformatf("rand%0d", i), rs, rl, rsh, ra, rb, mr, mc, mz, mv, ml);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
